// File: rtl/stream_demux.sv
// stream_demux: 1-to-2 registered stream demultiplexer.
//
// Each word accepted on the input is steered by in_sel into a one-entry
// output register for consumer 0 or consumer 1. Latency is one cycle, and
// each output sustains one word per cycle when its consumer keeps ready high.
//
// Ports:
//   clk                 single clock, rising edge
//   rst                 synchronous, active-high reset
//   in_valid/in_ready   producer handshake (in_ready is combinational)
//   in_data [WIDTH]     producer word
//   in_sel              destination: 0 -> out0, 1 -> out1
//   out0_valid/ready    consumer 0 handshake
//   out0_data [WIDTH]   consumer 0 register contents
//   out1_valid/ready    consumer 1 handshake
//   out1_data [WIDTH]   consumer 1 register contents
//   cnt0/cnt1 [CNT_W]   completed-transfer counters per output
//                       (only when STREAM_DEMUX_STATS_EN is defined)
//
// Output register states (per output k):
//   state | meaning
//   EMPTY | outk_valid = 0, outk_data holds the last delivered word
//   FULL  | outk_valid = 1, outk_data is stable until consumer k takes it
//
// Optional feature macro: STREAM_DEMUX_STATS_EN
module stream_demux #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data
`ifdef STREAM_DEMUX_STATS_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
`endif
);

    // Reject nonsensical parameterisations at elaboration time.
    if (WIDTH < 1 || CNT_W < 1) begin : g_bad_params
        $error("stream_demux: WIDTH and CNT_W must be at least 1");
    end

    logic             out0_valid_q, out0_valid_d;
    logic             out1_valid_q, out1_valid_d;
    logic [WIDTH-1:0] out0_data_q, out0_data_d;
    logic [WIDTH-1:0] out1_data_q, out1_data_d;

    logic load0, load1;
    logic drain0, drain1;

    // A slot can accept when it is empty or is being drained this same cycle;
    // only the selected slot matters, so a stalled sibling never blocks.
    always_comb begin
        in_ready = ~rst & (in_sel ? (~out1_valid_q | out1_ready)
                                  : (~out0_valid_q | out0_ready));
    end

    always_comb begin
        load0  = in_valid & in_ready & ~in_sel;
        load1  = in_valid & in_ready &  in_sel;
        drain0 = out0_valid_q & out0_ready;
        drain1 = out1_valid_q & out1_ready;

        out0_valid_d = load0 | (out0_valid_q & ~out0_ready);
        out1_valid_d = load1 | (out1_valid_q & ~out1_ready);

        // Data only changes on a load; a bare drain leaves the last word.
        out0_data_d = load0 ? in_data : out0_data_q;
        out1_data_d = load1 ? in_data : out1_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out0_valid_q <= 1'b0;
            out1_valid_q <= 1'b0;
            out0_data_q  <= '0;
            out1_data_q  <= '0;
        end else begin
            out0_valid_q <= out0_valid_d;
            out1_valid_q <= out1_valid_d;
            out0_data_q  <= out0_data_d;
            out1_data_q  <= out1_data_d;
        end
    end

    assign out0_valid = out0_valid_q;
    assign out1_valid = out1_valid_q;
    assign out0_data  = out0_data_q;
    assign out1_data  = out1_data_q;

`ifdef STREAM_DEMUX_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    // Free-running counts of completed output transfers; wrap naturally.
    always_comb begin
        cnt0_d = drain0 ? cnt0_q + CNT_W'(1) : cnt0_q;
        cnt1_d = drain1 ? cnt1_q + CNT_W'(1) : cnt1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`else
    // Drain strobes only feed the counters; keep them referenced.
    logic unused_drain;
    assign unused_drain = drain0 ^ drain1;
`endif

endmodule
